// File: rtl/mips_multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mips_ctrl_pkg
//  Purpose : Shared encodings for the multi-cycle MIPS control FSM: opcodes,
//            ALUOp, ALU B-source and PC-source selects, state enum and the
//            packed control word produced by the output decoder.
//  Options : ILLEGAL_OP_TRAP_EN (TRAP state is reachable only when defined)
//  Rev     : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // ALUOp handed to the ALU controller
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_SLT  = 2'b10;
    localparam logic [1:0] ALUOP_FUNC = 2'b11;

    // ALU B operand select
    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Fixed state encoding; 14 and 15 are unused and recover to INIT
    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_WB_LW    = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EX     = 4'd7,
        S_R_WB     = 4'd8,
        S_BEQ_EX   = 4'd9,
        S_SLTI_EX  = 4'd10,
        S_SLTI_WB  = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } ctrl_state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module  : mips_multicycle_controller_if
//  Purpose : Bundle between the control FSM (master) and the datapath
//            (slave): opcode and memory handshake in, control word out.
//  Rev     : 1.0  initial release
// ============================================================================
interface mips_multicycle_controller_if #(
    parameter int OPW  = 6,
    parameter int SW_W = 4
);
    logic [OPW-1:0]  opcode;
    logic            mem_ready;
    logic            pc_write;
    logic            pc_write_cond;
    logic [1:0]      pc_src;
    logic            i_or_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic            illegal;
    logic [SW_W-1:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, illegal, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, illegal, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_controller_outdec.sv
`default_nettype none
// ============================================================================
//  Module  : mips_ctrl_outdec
//  Purpose : Combinational state -> control-word decoder. Moore outputs,
//            except pc_write/ir_write in FETCH which follow mem_ready.
//  Options : ILLEGAL_OP_TRAP_EN (drives illegal in TRAP)
//  Rev     : 1.0  initial release
// ============================================================================
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  ctrl_state_t state_i,
    input  logic        mem_ready_i,
    output ctrl_word_t  ctrl_o
);

    // Every field defaults to 0; each state raises only what it needs
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ALUB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ctrl_o.alu_src_b = ALUB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_WB_LW: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_R_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_RT;
                ctrl_o.alu_op    = ALUOP_FUNC;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BEQ_EX: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUB_RT;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
            end
            S_SLTI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
                ctrl_o.alu_op    = ALUOP_SLT;
            end
            S_SLTI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                ctrl_o.illegal = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module  : mips_multicycle_controller
//  Purpose : Main control FSM of the multi-cycle MIPS datapath. Sequences one
//            state per clock, stalls memory states on mem_ready.
//  Options : ILLEGAL_OP_TRAP_EN - unknown opcode locks into TRAP until reset;
//            when undefined an unknown opcode behaves as a NOP.
//  Rev     : 1.0  initial release
// ============================================================================
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int SW_W = 4
) (
    input  wire                          clk,
    input  wire                          rst_n,
    mips_multicycle_controller_if.master bus
);

    ctrl_state_t    state_q;
    ctrl_state_t    state_d;
    ctrl_word_t     ctrl_w;
    logic [OPW-1:0] opcode_w;

    assign opcode_w = bus.opcode;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to INIT
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:     state_d = S_FETCH;
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_w)
                    OPW'(OPC_LW),
                    OPW'(OPC_SW):    state_d = S_MEM_ADDR;
                    OPW'(OPC_RTYPE): state_d = S_R_EX;
                    OPW'(OPC_BEQ):   state_d = S_BEQ_EX;
                    OPW'(OPC_SLTI):  state_d = S_SLTI_EX;
                    OPW'(OPC_J):     state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:         state_d = S_TRAP;
`else
                    default:         state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: state_d = (opcode_w == OPW'(OPC_LW)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = bus.mem_ready ? S_WB_LW : S_MEM_RD;
            S_WB_LW:    state_d = S_FETCH;
            S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BEQ_EX:   state_d = S_FETCH;
            S_SLTI_EX:  state_d = S_SLTI_WB;
            S_SLTI_WB:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_INIT;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl_w)
    );

    assign bus.pc_write      = ctrl_w.pc_write;
    assign bus.pc_write_cond = ctrl_w.pc_write_cond;
    assign bus.pc_src        = ctrl_w.pc_src;
    assign bus.i_or_d        = ctrl_w.i_or_d;
    assign bus.mem_read      = ctrl_w.mem_read;
    assign bus.mem_write     = ctrl_w.mem_write;
    assign bus.ir_write      = ctrl_w.ir_write;
    assign bus.mem_to_reg    = ctrl_w.mem_to_reg;
    assign bus.reg_dst       = ctrl_w.reg_dst;
    assign bus.reg_write     = ctrl_w.reg_write;
    assign bus.alu_src_a     = ctrl_w.alu_src_a;
    assign bus.alu_src_b     = ctrl_w.alu_src_b;
    assign bus.alu_op        = ctrl_w.alu_op;
    assign bus.illegal       = ctrl_w.illegal;
    assign bus.state_dbg     = SW_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mips_multicycle_controller
//  Purpose : Directed self-checking bench for mips_multicycle_controller.
//            Expected control words are written out by hand per state.
//  Options : ILLEGAL_OP_TRAP_EN selects the TRAP expectations
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_controller;
    import mips_ctrl_pkg::*;

    // Word layout: pcw pcwc pcsrc[2] iord mr mw irw m2r rd rw asa asb[2] aop[2] ill
    localparam logic [16:0] W_ZERO    = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [16:0] W_FETCH_W = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
    localparam logic [16:0] W_FETCH_R = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
    localparam logic [16:0] W_DECODE  = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
    localparam logic [16:0] W_MADDR   = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [16:0] W_MRD     = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
    localparam logic [16:0] W_WBLW    = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_0;
    localparam logic [16:0] W_MWR     = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
    localparam logic [16:0] W_REX     = 17'b0_0_00_0_0_0_0_0_0_0_1_00_11_0;
    localparam logic [16:0] W_RWB     = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [16:0] W_BEQ     = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_0;
    localparam logic [16:0] W_SEX     = 17'b0_0_00_0_0_0_0_0_0_0_1_10_10_0;
    localparam logic [16:0] W_SWB     = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_0;
    localparam logic [16:0] W_JMP     = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [16:0] W_TRAP    = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_1;
    localparam logic [5:0]  OP_ILL    = 6'b111111;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mips_multicycle_controller_if #(.OPW(6), .SW_W(4)) bus ();

    mips_multicycle_controller #(.OPW(6), .SW_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] obs_word();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.illegal};
    endfunction

    task automatic chk_now(input string tag, input ctrl_state_t st, input logic [16:0] w);
        logic [3:0]  exp_st;
        logic [16:0] ow;
        exp_st = 4'(st);
        ow     = obs_word();
        checks++;
        assert (bus.state_dbg === exp_st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state_dbg, exp_st);
        end
        checks++;
        assert (ow === w) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, ow, w);
        end
        checks++;
        assert (!(bus.mem_read === 1'b1 && bus.mem_write === 1'b1)) else begin
            errors++;
            $error("FAIL %s rd_wr_excl observed=11 expected=not both", tag);
        end
    endtask

    // Called at a negedge: apply inputs, check, then advance one full cycle
    task automatic step(input string tag, input ctrl_state_t st, input logic [16:0] w,
                        input logic rdy, input logic [5:0] op);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        #1;
        chk_now(tag, st, w);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        @(negedge clk);

        // Reset held for 3 cycles; mem_ready must not matter
        step("rst0", S_INIT, W_ZERO, 1'b1, OPC_LW);
        step("rst1", S_INIT, W_ZERO, 1'b0, OPC_LW);
        step("rst2", S_INIT, W_ZERO, 1'b1, OPC_LW);
        rst_n = 1'b1;
        step("init", S_INIT, W_ZERO, 1'b1, OPC_LW);

        // LW with 2 wait cycles in FETCH and in MEM_RD: 9 cycles
        step("lw_f0", S_FETCH,    W_FETCH_W, 1'b0, OPC_LW);
        step("lw_f1", S_FETCH,    W_FETCH_W, 1'b0, OPC_LW);
        step("lw_f2", S_FETCH,    W_FETCH_R, 1'b1, OPC_LW);
        step("lw_dc", S_DECODE,   W_DECODE,  1'b1, OPC_LW);
        step("lw_ma", S_MEM_ADDR, W_MADDR,   1'b0, OPC_LW);
        step("lw_r0", S_MEM_RD,   W_MRD,     1'b0, OPC_LW);
        step("lw_r1", S_MEM_RD,   W_MRD,     1'b0, OPC_LW);
        step("lw_r2", S_MEM_RD,   W_MRD,     1'b1, OPC_LW);
        step("lw_wb", S_WB_LW,    W_WBLW,    1'b1, OPC_LW);

        // SW, zero wait
        step("sw_f",  S_FETCH,    W_FETCH_R, 1'b1, OPC_SW);
        step("sw_dc", S_DECODE,   W_DECODE,  1'b0, OPC_SW);
        step("sw_ma", S_MEM_ADDR, W_MADDR,   1'b1, OPC_SW);
        step("sw_wr", S_MEM_WR,   W_MWR,     1'b1, OPC_SW);

        // R-type
        step("r_f",   S_FETCH,    W_FETCH_R, 1'b1, OPC_RTYPE);
        step("r_dc",  S_DECODE,   W_DECODE,  1'b1, OPC_RTYPE);
        step("r_ex",  S_R_EX,     W_REX,     1'b1, OPC_RTYPE);
        step("r_wb",  S_R_WB,     W_RWB,     1'b0, OPC_RTYPE);

        // SLTI
        step("s_f",   S_FETCH,    W_FETCH_R, 1'b1, OPC_SLTI);
        step("s_dc",  S_DECODE,   W_DECODE,  1'b0, OPC_SLTI);
        step("s_ex",  S_SLTI_EX,  W_SEX,     1'b0, OPC_SLTI);
        step("s_wb",  S_SLTI_WB,  W_SWB,     1'b1, OPC_SLTI);

        // BEQ
        step("b_f",   S_FETCH,    W_FETCH_R, 1'b1, OPC_BEQ);
        step("b_dc",  S_DECODE,   W_DECODE,  1'b1, OPC_BEQ);
        step("b_ex",  S_BEQ_EX,   W_BEQ,     1'b0, OPC_BEQ);

        // J
        step("j_f",   S_FETCH,    W_FETCH_R, 1'b1, OPC_J);
        step("j_dc",  S_DECODE,   W_DECODE,  1'b0, OPC_J);
        step("j_ex",  S_JUMP,     W_JMP,     1'b1, OPC_J);

        // Illegal opcode
        step("il_f",  S_FETCH,    W_FETCH_R, 1'b1, OP_ILL);
        step("il_dc", S_DECODE,   W_DECODE,  1'b1, OP_ILL);
`ifdef ILLEGAL_OP_TRAP_EN
        step("il_t0", S_TRAP,     W_TRAP,    1'b1, OP_ILL);
        step("il_t1", S_TRAP,     W_TRAP,    1'b0, OPC_LW);
        step("il_t2", S_TRAP,     W_TRAP,    1'b1, OPC_RTYPE);
        rst_n = 1'b0;
        step("il_rst", S_INIT,    W_ZERO,    1'b1, OPC_LW);
        rst_n = 1'b1;
        step("il_ini", S_INIT,    W_ZERO,    1'b1, OPC_LW);
`endif
        step("il_nx", S_FETCH,    W_FETCH_W, 1'b0, OPC_LW);

        // Reset pulse mid MEM_RD with mem_ready asserted: no write-back follows
        step("ab_f",  S_FETCH,    W_FETCH_R, 1'b1, OPC_LW);
        step("ab_dc", S_DECODE,   W_DECODE,  1'b1, OPC_LW);
        step("ab_ma", S_MEM_ADDR, W_MADDR,   1'b1, OPC_LW);
        bus.mem_ready = 1'b1;
        #1;
        chk_now("ab_rd", S_MEM_RD, W_MRD);
        #1;
        rst_n = 1'b0;
        #1;
        chk_now("ab_rst", S_INIT, W_ZERO);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step("ab_f0", S_FETCH,    W_FETCH_W, 1'b0, OPC_LW);
        step("ab_f1", S_FETCH,    W_FETCH_R, 1'b1, OPC_LW);
        step("ab_d1", S_DECODE,   W_DECODE,  1'b0, OPC_LW);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
